// File: rtl/run_ctrl.sv
// run_ctrl: program-run sequencer between a req/done handshake and the core.
// Holds the core in reset for CLR_CYC cycles after a start, runs it until the
// PC reaches start_addr + END_PC (mod 2^D), then freezes it and reports done.
// Optional watchdog: define RUN_CTRL_WATCHDOG_EN to end a run after TMO cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | core held in reset, waiting for a 0->1 transition on req
// CLEAR | core held in reset for CLR_CYC cycles, PC loads start_addr
// RUN   | core enabled, cycles counted, halt/watchdog evaluated
// DONE  | core frozen with state visible, done=1 until req drops
module run_ctrl #(
    parameter int D       = 12,
    parameter int CLR_CYC = 2,
    parameter int END_PC  = 128,
    parameter int CW      = 16,
    parameter int TMO     = 4096
) (
    input  logic          clk_i,
    input  logic          reset_i,      // asynchronous, active-low
    input  logic          req_i,
    input  logic [1:0]    prog_sel_i,
    input  logic [D-1:0]  prog_ctr_i,
    output logic          core_rst_o,
    output logic          core_en_o,
    output logic [D-1:0]  start_addr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic [CW-1:0] cyc_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          req_q;
    logic [3:0]    clr_cnt_q, clr_cnt_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [D-1:0]  start_addr_q, start_addr_d;
    logic          start;
    logic          halt;
    logic [D-1:0]  end_addr;

    assign start    = req_i & ~req_q;
    // End address wraps naturally at D bits.
    assign end_addr = start_addr_q + D'(END_PC);
    assign halt     = (prog_ctr_i == end_addr);

`ifdef RUN_CTRL_WATCHDOG_EN
    logic timeout_q, timeout_d;
    logic wdog_hit;

    assign wdog_hit  = (cyc_cnt_q == CW'(TMO - 1));
    assign timeout_o = timeout_q;

    // Watchdog flag register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) timeout_q <= 1'b0;
        else          timeout_q <= timeout_d;
    end
`else
    assign timeout_o = 1'b0;
`endif

    // State, edge-detect and run bookkeeping registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            clr_cnt_q    <= '0;
            cyc_cnt_q    <= '0;
            start_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_i;
            clr_cnt_q    <= clr_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            start_addr_q <= start_addr_d;
        end
    end

    // Next-state and bookkeeping updates.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        start_addr_d = start_addr_q;
`ifdef RUN_CTRL_WATCHDOG_EN
        timeout_d    = timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_addr_d = {prog_sel_i, {(D-2){1'b0}}};
                    cyc_cnt_d    = '0;
                    clr_cnt_d    = 4'(CLR_CYC - 1);
`ifdef RUN_CTRL_WATCHDOG_EN
                    timeout_d    = 1'b0;
`endif
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == 4'd0) state_d = S_RUN;
                else                   clr_cnt_d = clr_cnt_q - 4'd1;
            end
            S_RUN: begin
                if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + 1'b1;
                // Halt has priority over the watchdog in the same cycle.
                if (halt) begin
                    state_d = S_DONE;
                end
`ifdef RUN_CTRL_WATCHDOG_EN
                else if (wdog_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (!req_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_rst_o   = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign core_en_o    = (state_q == S_RUN);
    assign busy_o       = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);
    assign start_addr_o = start_addr_q;
    assign cyc_cnt_o    = cyc_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (default parameters with a counting PC
// model, and a small one with bench-driven PC), expected run results queued
// at start and scored when done rises.
module tb_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_a, req_b;
    logic [1:0]  sel_a, sel_b;
    logic [11:0] pc_a, pc_b;

    logic        core_rst_a, core_en_a, busy_a, done_a, timeout_a;
    logic [11:0] start_addr_a;
    logic [15:0] cyc_a;
    logic        core_rst_b, core_en_b, busy_b, done_b, timeout_b;
    logic [11:0] start_addr_b;
    logic [4:0]  cyc_b;

    run_ctrl u_dut_a (
        .clk_i(clk), .reset_i(rst_n), .req_i(req_a), .prog_sel_i(sel_a),
        .prog_ctr_i(pc_a), .core_rst_o(core_rst_a), .core_en_o(core_en_a),
        .start_addr_o(start_addr_a), .busy_o(busy_a), .done_o(done_a),
        .timeout_o(timeout_a), .cyc_cnt_o(cyc_a)
    );

    run_ctrl #(.D(12), .CLR_CYC(1), .END_PC('h500), .CW(5), .TMO(16)) u_dut_b (
        .clk_i(clk), .reset_i(rst_n), .req_i(req_b), .prog_sel_i(sel_b),
        .prog_ctr_i(pc_b), .core_rst_o(core_rst_b), .core_en_o(core_en_b),
        .start_addr_o(start_addr_b), .busy_o(busy_b), .done_o(done_b),
        .timeout_o(timeout_b), .cyc_cnt_o(cyc_b)
    );

    typedef struct {
        logic [15:0] cyc;
        logic        tmo;
        logic [11:0] addr;
        int          clr;
        logic [11:0] pc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic score(input string who, input exp_t e, input logic [15:0] cyc,
                         input logic tmo, input logic [11:0] addr, input int clr,
                         input logic en);
        check({who, "_cyc"},     cyc,  e.cyc);
        check({who, "_timeout"}, tmo,  e.tmo);
        check({who, "_addr"},    addr, e.addr);
        check({who, "_clr"},     clr,  e.clr);
        check({who, "_en_off"},  en,   1'b0);
    endtask

    // Core PC model for instance A: load on core_rst, advance on core_en.
    always @(posedge clk) begin
        if (core_rst_a)     pc_a <= start_addr_a;
        else if (core_en_a) pc_a <= pc_a + 12'd1;
    end

    logic busy_a_d = 1'b0, done_a_d = 1'b0, busy_b_d = 1'b0, done_b_d = 1'b0;
    int   clr_a = 0, clr_b = 0, runs_a = 0;

    always @(negedge clk) begin
        if (busy_a && !busy_a_d) begin runs_a++; clr_a = 0; end
        if (busy_a && core_rst_a) clr_a++;
        if (done_a && !done_a_d) begin
            if (q_a.size() == 0) check("a_unexpected_done", done_a, 1'b0);
            else begin
                e_a = q_a.pop_front();
                score("a", e_a, cyc_a, timeout_a, start_addr_a, clr_a, core_en_a);
                check("a_pc_frozen", pc_a, e_a.pc);
            end
        end
        if (busy_b && !busy_b_d) clr_b = 0;
        if (busy_b && core_rst_b) clr_b++;
        if (done_b && !done_b_d) begin
            if (q_b.size() == 0) check("b_unexpected_done", done_b, 1'b0);
            else begin
                e_b = q_b.pop_front();
                score("b", e_b, {11'd0, cyc_b}, timeout_b, start_addr_b, clr_b, core_en_b);
            end
        end
        busy_a_d = busy_a; done_a_d = done_a;
        busy_b_d = busy_b; done_b_d = done_b;
    end

    task automatic wait_done_a(input int budget);
        for (int i = 0; i < budget && !done_a; i++) @(negedge clk);
        check("a_done_reached", done_a, 1'b1);
    endtask

    // Run on instance B: halt PC presented in RUN cycle h (h=0: never).
    task automatic run_b(input logic [1:0] sel, input int h, input logic [11:0] halt_pc,
                         input logic [11:0] other_pc, input int budget);
        int n;
        n     = 0;
        pc_b  = other_pc;
        sel_b = sel;
        req_b = 1'b1;
        for (int i = 0; i < budget && !done_b; i++) begin
            @(negedge clk);
            if (core_en_b) begin
                n++;
                pc_b = (n == h) ? halt_pc : other_pc;
            end
        end
        check("b_done_reached", done_b, 1'b1);
        req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int busy_seen;
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        sel_a = 2'd0; sel_b = 2'd0; pc_b = 12'd0;
        repeat (3) @(negedge clk);
        check("rst_core_rst", core_rst_a, 1'b1);
        check("rst_core_en",  core_en_a,  1'b0);
        check("rst_busy",     busy_a,     1'b0);
        check("rst_done",     done_a,     1'b0);
        check("rst_timeout",  timeout_a,  1'b0);
        check("rst_cyc",      cyc_a,      16'd0);
        check("rst_addr",     start_addr_a, 12'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Run 1: prog_sel=1, start 0x400, halt at 0x480 after 129 cycles.
        q_a.push_back('{cyc: 16'd129, tmo: 1'b0, addr: 12'h400, clr: 2, pc: 12'h481});
        sel_a = 2'd1; req_a = 1'b1;
        repeat (6) @(negedge clk);
        sel_a = 2'd2;
        wait_done_a(400);
        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy_a) busy_seen++;
        end
        check("a_busy_in_done", busy_seen, 0);
        check("a_done_held",    done_a,    1'b1);
        req_a = 1'b0;
        @(negedge clk);
        check("a_idle_done",     done_a,     1'b0);
        check("a_idle_core_rst", core_rst_a, 1'b1);
        check("a_idle_cyc_hold", cyc_a,      16'd129);
        check("a_runs_1",        runs_a,     1);

        // Run 2: req drops during CLEAR, run still completes.
        q_a.push_back('{cyc: 16'd129, tmo: 1'b0, addr: 12'h000, clr: 2, pc: 12'h081});
        sel_a = 2'd0; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        wait_done_a(400);
        @(negedge clk);
        check("a_done_1cyc", done_a, 1'b0);
        repeat (3) @(negedge clk);
        check("a_cyc_hold_idle", cyc_a,  16'd129);
        check("a_runs_2",        runs_a, 2);

        // Run 3: reset mid-RUN.
        sel_a = 2'd3; req_a = 1'b1;
        repeat (12) @(negedge clk);
        check("a_midrun_busy", busy_a, 1'b1);
        rst_n = 1'b0; req_a = 1'b0;
        #1;
        check("mr_core_rst", core_rst_a, 1'b1);
        check("mr_core_en",  core_en_a,  1'b0);
        check("mr_busy",     busy_a,     1'b0);
        check("mr_done",     done_a,     1'b0);
        check("mr_cyc",      cyc_a,      16'd0);
        check("mr_addr",     start_addr_a, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("mr_no_restart", runs_a, 3);
        check("mr_idle_busy",  busy_a, 1'b0);

        // Instance B: wrapped end address 0xC00+0x500 -> 0x100.
        q_b.push_back('{cyc: 16'd5, tmo: 1'b0, addr: 12'hC00, clr: 1, pc: 12'h0});
        run_b(2'd3, 5, 12'h100, 12'h500, 100);
        // Halt in the very first RUN cycle.
        q_b.push_back('{cyc: 16'd1, tmo: 1'b0, addr: 12'h000, clr: 1, pc: 12'h0});
        run_b(2'd0, 1, 12'h500, 12'h000, 100);
`ifdef RUN_CTRL_WATCHDOG_EN
        // PC stuck: watchdog ends the run after TMO cycles.
        q_b.push_back('{cyc: 16'd16, tmo: 1'b1, addr: 12'h400, clr: 1, pc: 12'h0});
        run_b(2'd1, 0, 12'h000, 12'h000, 100);
        // Halt together with watchdog: halt wins.
        q_b.push_back('{cyc: 16'd16, tmo: 1'b0, addr: 12'h800, clr: 1, pc: 12'h0});
        run_b(2'd2, 16, 12'hD00, 12'h000, 100);
`else
        // Long run: counter saturates at 31.
        q_b.push_back('{cyc: 16'd31, tmo: 1'b0, addr: 12'h400, clr: 1, pc: 12'h0});
        run_b(2'd1, 40, 12'h900, 12'h000, 100);
`endif
        repeat (2) @(negedge clk);
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
